// File: rtl/stq_pkg.sv
// Shared types for the store queue: entry record, drain FSM states, mask helper.
// Entry fields are sized for the widest legal address/branch mask; narrower configs zero-extend.
package stq_pkg;

    localparam int STQ_ADDR_MAX = 32;
    localparam int STQ_BRM_MAX  = 32;

    typedef struct packed {
        logic                    valid;
        logic                    committed;
        logic [STQ_BRM_MAX-1:0]  brmask;
        logic [STQ_ADDR_MAX-1:0] addr;
        logic [31:0]             data;
    } stq_entry_t;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;

    function automatic logic mask_hit(input logic [STQ_BRM_MAX-1:0] m,
                                      input logic [STQ_BRM_MAX-1:0] k);
        return |(m & k);
    endfunction

endpackage

// File: rtl/stq_age_match.sv
// Purpose: per-entry address compare, one-hot select of the youngest matching entry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the current queue contents.
module stq_age_match
    import stq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]              valid,
    input  logic [DEPTH*STQ_ADDR_MAX-1:0] addr_flat,
    input  logic [STQ_ADDR_MAX-1:0]       ld_addr,
    input  logic [$clog2(DEPTH)-1:0]      tail,
    output logic [DEPTH-1:0]              sel
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    idx;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (addr_flat[i*STQ_ADDR_MAX +: STQ_ADDR_MAX] == ld_addr);
        end
    end

    // Walk from the oldest slot (tail-DEPTH, i.e. tail) towards tail-1; the last hit is the youngest.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (match[idx]) begin
                sel      = '0;
                sel[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stq_forward.sv
// Purpose: store queue with branch kill, in-order dcache drain and store-to-load forwarding (STQ_FWD_EN; else load stall).
// Latency: allocate/commit take effect next edge; drain write starts one cycle after head commits; forwarding is combinational.
// Backpressure: o_st_rdy low when full (drains do not free a slot same cycle); dcache_o_nack holds the head write.
module stq_forward
    import stq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH_MEM = 4,
    parameter int WIDTH_BRM = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_st_val,
    input  logic [WIDTH_MEM-1:0] i_st_addr,
    input  logic [31:0]          i_st_data,
    input  logic [WIDTH_BRM-1:0] i_st_brmask,
    output logic                 o_st_rdy,
    input  logic                 i_commit,
    input  logic [WIDTH_BRM-1:0] i_brkill,
    input  logic [WIDTH_BRM-1:0] i_brclr,
    input  logic                 i_ld_val,
    input  logic [WIDTH_MEM-1:0] i_ld_addr,
    output logic                 o_fwd_hit,
    output logic [31:0]          o_fwd_data,
    output logic                 o_ld_stall,
    output logic [WIDTH_MEM-1:0] dcache_i_addr,
    output logic [31:0]          dcache_i_data,
    output logic                 dcache_i_we,
    input  logic                 dcache_o_nack,
    output logic                 o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stq_entry_t   entries [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    drain_state_t  state, state_nx;

    logic [STQ_BRM_MAX-1:0] kill_ext, clr_ext, st_mask_ext;
    logic                   st_rdy, alloc, retire, commit_fire;
    logic [PW-1:0]          commit_idx, cidx, head_nx1;
    stq_entry_t             head_e, next_e, alloc_e;

    assign kill_ext    = STQ_BRM_MAX'(i_brkill);
    assign clr_ext     = STQ_BRM_MAX'(i_brclr);
    assign st_mask_ext = STQ_BRM_MAX'(i_st_brmask);

    assign st_rdy   = (count != CW'(DEPTH));
    assign alloc    = i_st_val && st_rdy && !mask_hit(st_mask_ext, kill_ext);
    assign head_nx1 = head + PW'(1);
    assign head_e   = entries[head];
    assign next_e   = entries[head_nx1];

    always_comb begin
        alloc_e           = '0;
        alloc_e.valid     = 1'b1;
        alloc_e.committed = 1'b0;
        alloc_e.brmask    = st_mask_ext & ~clr_ext;
        alloc_e.addr      = STQ_ADDR_MAX'(i_st_addr);
        alloc_e.data      = i_st_data;
    end

    // Scan youngest to oldest so the last qualifying slot is the oldest pending one.
    always_comb begin
        commit_fire = 1'b0;
        commit_idx  = '0;
        cidx        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            cidx = head + PW'(k);
            if ((CW'(k) < count) && entries[cidx].valid && !entries[cidx].committed &&
                !mask_hit(entries[cidx].brmask, kill_ext)) begin
                commit_fire = i_commit;
                commit_idx  = cidx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (count != '0) begin
                    if (!head_e.valid) begin
                        retire = 1'b1;
                    end else if (head_e.committed) begin
                        state_nx = DRAIN_WRITE;
                    end
                end
            end
            DRAIN_WRITE: begin
                if (!dcache_o_nack) begin
                    retire   = 1'b1;
                    state_nx = ((count > CW'(1)) && next_e.valid && next_e.committed)
                               ? DRAIN_WRITE : DRAIN_IDLE;
                end
            end
            default: state_nx = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= DRAIN_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            state <= state_nx;
            for (int i = 0; i < DEPTH; i++) begin
                if (!entries[i].committed && mask_hit(entries[i].brmask, kill_ext)) begin
                    entries[i].valid <= 1'b0;
                end
                entries[i].brmask <= entries[i].brmask & ~clr_ext;
            end
            if (commit_fire) begin
                entries[commit_idx].committed <= 1'b1;
            end
            if (retire) begin
                entries[head].valid <= 1'b0;
                head                <= head_nx1;
            end
            if (alloc) begin
                entries[tail] <= alloc_e;
                tail          <= tail + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(retire);
        end
    end

    assign o_st_rdy      = st_rdy;
    assign o_empty       = (count == '0);
    assign dcache_i_we   = (state == DRAIN_WRITE);
    assign dcache_i_addr = dcache_i_we ? head_e.addr[WIDTH_MEM-1:0] : '0;
    assign dcache_i_data = dcache_i_we ? head_e.data : '0;

    logic [DEPTH-1:0]              ent_valid;
    logic [DEPTH*STQ_ADDR_MAX-1:0] ent_addr;
    logic [DEPTH-1:0]              fwd_sel;

    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]                                 = entries[i].valid;
            ent_addr[i*STQ_ADDR_MAX +: STQ_ADDR_MAX]     = entries[i].addr;
        end
    end

    stq_age_match #(.DEPTH(DEPTH)) u_age_match (
        .valid     (ent_valid),
        .addr_flat (ent_addr),
        .ld_addr   (STQ_ADDR_MAX'(i_ld_addr)),
        .tail      (tail),
        .sel       (fwd_sel)
    );

`ifdef STQ_FWD_EN
    logic [31:0] fwd_mux;

    always_comb begin
        fwd_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_sel[i]) begin
                fwd_mux = entries[i].data;
            end
        end
    end

    assign o_fwd_hit  = i_ld_val && (|fwd_sel);
    assign o_fwd_data = o_fwd_hit ? fwd_mux : '0;
    assign o_ld_stall = 1'b0;
`else
    assign o_fwd_hit  = 1'b0;
    assign o_fwd_data = '0;
    assign o_ld_stall = i_ld_val && (|fwd_sel);
`endif

endmodule

// File: tb/tb_stq_forward.sv
// Bench for stq_forward: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the store queue.
module tb_stq_forward;

    localparam int DEPTH = 8;
    localparam int WM    = 4;
    localparam int WB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st_val = 1'b0;
    logic [WM-1:0] st_addr = '0;
    logic [31:0]   st_data = '0;
    logic [WB-1:0] st_mask = '0;
    logic          commit = 1'b0;
    logic [WB-1:0] brkill = '0;
    logic [WB-1:0] brclr = '0;
    logic          ld_val = 1'b0;
    logic [WM-1:0] ld_addr = '0;
    logic          nack = 1'b0;

    logic          o_st_rdy, o_fwd_hit, o_ld_stall, dcache_i_we, o_empty;
    logic [31:0]   o_fwd_data, dcache_i_data;
    logic [WM-1:0] dcache_i_addr;

    stq_forward #(.DEPTH(DEPTH), .WIDTH_MEM(WM), .WIDTH_BRM(WB)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_st_val      (st_val),
        .i_st_addr     (st_addr),
        .i_st_data     (st_data),
        .i_st_brmask   (st_mask),
        .o_st_rdy      (o_st_rdy),
        .i_commit      (commit),
        .i_brkill      (brkill),
        .i_brclr       (brclr),
        .i_ld_val      (ld_val),
        .i_ld_addr     (ld_addr),
        .o_fwd_hit     (o_fwd_hit),
        .o_fwd_data    (o_fwd_data),
        .o_ld_stall    (o_ld_stall),
        .dcache_i_addr (dcache_i_addr),
        .dcache_i_data (dcache_i_data),
        .dcache_i_we   (dcache_i_we),
        .dcache_o_nack (nack),
        .o_empty       (o_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: program-ordered list of stores, oldest at index 0, plus "head is being written".
    typedef struct {
        bit          valid;
        bit          committed;
        bit [WB-1:0] mask;
        bit [WM-1:0] addr;
        bit [31:0]   data;
    } me_t;

    me_t mq[$];
    bit  m_busy = 1'b0;
    bit  m_ok   = 1'b0;

    always @(posedge clk) begin : model
        bit  rdy, alloc, pop, busy_n;
        int  ct;
        me_t e;
        if (rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_ok   = 1'b1;
        end else begin
            rdy   = (mq.size() != DEPTH);
            alloc = st_val && rdy && ((st_mask & brkill) == 0);
            ct    = -1;
            if (commit) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (ct < 0 && mq[i].valid && !mq[i].committed && (mq[i].mask & brkill) == 0)
                        ct = i;
                end
            end
            pop    = 1'b0;
            busy_n = m_busy;
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    if (!mq[0].valid) pop = 1'b1;
                    else if (mq[0].committed) busy_n = 1'b1;
                end
            end else if (!nack) begin
                pop    = 1'b1;
                busy_n = (mq.size() > 1) && mq[1].valid && mq[1].committed;
            end
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].committed && (mq[i].mask & brkill) != 0) mq[i].valid = 1'b0;
                mq[i].mask = mq[i].mask & ~brclr;
            end
            if (ct >= 0) mq[ct].committed = 1'b1;
            if (pop) void'(mq.pop_front());
            if (alloc) begin
                e.valid     = 1'b1;
                e.committed = 1'b0;
                e.mask      = st_mask & ~brclr;
                e.addr      = st_addr;
                e.data      = st_data;
                mq.push_back(e);
            end
            m_busy = busy_n;
        end
    end

    always @(negedge clk) begin : cmp
        bit          found;
        logic [31:0] edat;
        if (m_ok) begin
            chk("st_rdy", 32'(o_st_rdy), 32'(mq.size() != DEPTH));
            chk("empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("dc_we", 32'(dcache_i_we), 32'(m_busy));
            chk("dc_addr", 32'(dcache_i_addr), m_busy ? 32'(mq[0].addr) : 32'd0);
            chk("dc_data", dcache_i_data, m_busy ? mq[0].data : 32'd0);
            found = 1'b0;
            edat  = '0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!found && mq[i].valid && mq[i].addr == ld_addr) begin
                    found = 1'b1;
                    edat  = mq[i].data;
                end
            end
            found = found && ld_val;
`ifdef STQ_FWD_EN
            chk("fwd_hit", 32'(o_fwd_hit), 32'(found));
            chk("fwd_data", o_fwd_data, found ? edat : 32'd0);
            chk("ld_stall", 32'(o_ld_stall), 32'd0);
`else
            chk("fwd_hit", 32'(o_fwd_hit), 32'd0);
            chk("fwd_data", o_fwd_data, 32'd0);
            chk("ld_stall", 32'(o_ld_stall), 32'(found));
`endif
            if (!rst && dcache_i_we && !nack) begin
                wr_cnt++;
                wr_log.push_back(dcache_i_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_val = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
        commit = 1'b0; brkill = '0; brclr = '0; ld_val = 1'b0; ld_addr = '0; nack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input int lim);
        int n = 0;
        while (!o_empty && n < lim) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(o_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;

        // Reset values
        do_reset();
        ld_val = 1'b1; ld_addr = 4'd4;
        #1;
        chk("rst_rdy", 32'(o_st_rdy), 32'd1);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_we", 32'(dcache_i_we), 32'd0);
        chk("rst_hit", 32'(o_fwd_hit), 32'd0);
        chk("rst_stall", 32'(o_ld_stall), 32'd0);
        chk("rst_fdata", o_fwd_data, 32'd0);
        ld_val = 1'b0;

        // Single store through to dcache
        w0 = wr_cnt;
        st_val = 1'b1; st_addr = 4'd4; st_data = 32'hffff;
        tick();
        st_val = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("t1_we", 32'(dcache_i_we), 32'd1);
        chk("t1_addr", 32'(dcache_i_addr), 32'd4);
        chk("t1_data", dcache_i_data, 32'hffff);
        tick();
        chk("t1_we_off", 32'(dcache_i_we), 32'd0);
        chk("t1_empty", 32'(o_empty), 32'd1);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd1);

        // Fill to full, ninth store ignored, one drain frees a slot
        do_reset();
        w0 = wr_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            st_val = 1'b1; st_addr = WM'(i); st_data = 32'h200 + 32'(i);
            tick();
        end
        chk("full_rdy", 32'(o_st_rdy), 32'd0);
        st_data = 32'hdead;
        tick();
        chk("full_rdy_hold", 32'(o_st_rdy), 32'd0);
        st_val = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("full_drain_we", 32'(dcache_i_we), 32'd1);
        chk("full_drain_data", dcache_i_data, 32'h200);
        tick();
        chk("full_rdy_after", 32'(o_st_rdy), 32'd1);
        commit = 1'b1;
        wait_empty(100);
        commit = 1'b0;
        chk("full_writes", 32'(wr_cnt - w0), 32'd8);

        // Youngest-match forwarding
        do_reset();
        st_val = 1'b1; st_addr = 4'd4; st_data = 32'hf;
        tick();
        st_data = 32'hff;
        tick();
        st_val = 1'b0; ld_val = 1'b1; ld_addr = 4'd4;
        #1;
`ifdef STQ_FWD_EN
        chk("fwd4_hit", 32'(o_fwd_hit), 32'd1);
        chk("fwd4_data", o_fwd_data, 32'hff);
        chk("fwd4_stall", 32'(o_ld_stall), 32'd0);
`else
        chk("fwd4_hit", 32'(o_fwd_hit), 32'd0);
        chk("fwd4_data", o_fwd_data, 32'd0);
        chk("fwd4_stall", 32'(o_ld_stall), 32'd1);
`endif
        ld_addr = 4'd3;
        #1;
        chk("fwd3_hit", 32'(o_fwd_hit), 32'd0);
        chk("fwd3_stall", 32'(o_ld_stall), 32'd0);
        ld_val = 1'b0; commit = 1'b1;
        wait_empty(50);
        commit = 1'b0;

        // Branch kill before commit
        do_reset();
        w0 = wr_cnt;
        st_val = 1'b1; st_addr = 4'd5; st_mask = 4'h2; st_data = 32'h55;
        tick();
        st_val = 1'b0; st_mask = '0; brkill = 4'h2;
        tick();
        brkill = '0; ld_val = 1'b1; ld_addr = 4'd5;
        #1;
        chk("kill_hit", 32'(o_fwd_hit), 32'd0);
        chk("kill_stall", 32'(o_ld_stall), 32'd0);
        tick();
        chk("kill_empty", 32'(o_empty), 32'd1);
        chk("kill_we", 32'(dcache_i_we), 32'd0);
        chk("kill_writes", 32'(wr_cnt - w0), 32'd0);
        ld_val = 1'b0;

        // Nack holds the write
        do_reset();
        w0 = wr_cnt;
        st_val = 1'b1; st_addr = 4'd9; st_data = 32'h1234;
        tick();
        st_val = 1'b0; commit = 1'b1; nack = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("nack_we", 32'(dcache_i_we), 32'd1);
            chk("nack_addr", 32'(dcache_i_addr), 32'd9);
            chk("nack_data", dcache_i_data, 32'h1234);
            tick();
        end
        nack = 1'b0;
        chk("nack_we_last", 32'(dcache_i_we), 32'd1);
        tick();
        chk("nack_we_off", 32'(dcache_i_we), 32'd0);
        chk("nack_empty", 32'(o_empty), 32'd1);
        chk("nack_writes", 32'(wr_cnt - w0), 32'd1);

        // Reset during a write abandons it
        w0 = wr_cnt;
        st_val = 1'b1; st_addr = 4'd7; st_data = 32'h77;
        tick();
        st_val = 1'b0; commit = 1'b1; nack = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("rstw_we_pre", 32'(dcache_i_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; nack = 1'b0;
        chk("rstw_we", 32'(dcache_i_we), 32'd0);
        chk("rstw_empty", 32'(o_empty), 32'd1);
        tick();
        tick();
        chk("rstw_we_later", 32'(dcache_i_we), 32'd0);
        chk("rstw_writes", 32'(wr_cnt - w0), 32'd0);

        // Pointer wrap: 12 alloc/commit/drain rounds
        do_reset();
        w0 = wr_cnt;
        wr_log.delete();
        for (int i = 0; i < 12; i++) begin
            st_val = 1'b1; st_addr = WM'(i); st_data = 32'h300 + 32'(i);
            tick();
            st_val = 1'b0; commit = 1'b1;
            tick();
            commit = 1'b0;
            wait_empty(20);
        end
        chk("wrap_writes", 32'(wr_cnt - w0), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("wrap_order", (i < wr_log.size()) ? wr_log[i] : 32'hffff_ffff, 32'h300 + 32'(i));
        end
        chk("wrap_empty", 32'(o_empty), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 399) == 0);
            st_val  = ($urandom_range(0, 1) == 1);
            st_addr = WM'($urandom_range(0, 15));
            st_data = $urandom;
            st_mask = ($urandom_range(0, 1) == 1) ? WB'($urandom_range(0, 15)) : '0;
            brkill  = ($urandom_range(0, 19) == 0) ? WB'(32'd1 << $urandom_range(0, WB - 1)) : '0;
            brclr   = ($urandom_range(0, 5) == 0) ? (WB'($urandom_range(0, 15)) & ~brkill) : '0;
            commit  = (brkill == '0) && ($urandom_range(0, 9) < 4);
            nack    = ($urandom_range(0, 9) < 3);
            ld_val  = ($urandom_range(0, 1) == 1);
            ld_addr = WM'($urandom_range(0, 15));
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
